// File: rtl/word_access_sequencer_if.sv
// Bundles the request, response and byte-memory port of the word access
// sequencer. The slave modport is the sequencer's view. The master modport is
// the environment's view: the CPU load/store stage plus the byte memory.
interface word_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic        mem_enable;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/word_access_sequencer.sv
// Word access sequencer: takes one 8/16/32-bit load or store per request and
// performs it as one little-endian byte access per cycle on a byte-wide
// memory port. Alignment, size and range are checked when the request is
// accepted. A rejected request is answered without touching memory.
module word_access_sequencer #(
    parameter logic [31:0] MEMSIZE = 32'h400
) (
    input  logic                    clk,
    input  logic                    rst_n,
    word_access_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  k;          // index of the byte being transferred
    logic [1:0]  last_k;     // N-1 for the accepted request
    logic [31:0] base;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        err;

    logic [1:0]  req_last;
    logic [32:0] req_end;
    logic        req_err;
    logic        accept;

    // Decode the incoming request: last byte index and the error conditions.
    // The end address is 33 bits wide so a request near 32'hFFFFFFFF cannot
    // wrap around into range.
    always_comb begin
        req_last = 2'd0;
        case (bus.req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            2'b10:   req_last = 2'd3;
            default: req_last = 2'd0;
        endcase
        req_end = {1'b0, bus.req_addr} + {31'b0, req_last};
        req_err = (bus.req_size == 2'b11)
               || ((bus.req_size == 2'b01) && bus.req_addr[0])
               || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
               || (req_end >= {1'b0, MEMSIZE});
    end

    assign accept = bus.req_valid && (state == S_IDLE);

    // State register; reset returns to IDLE immediately, which also drops
    // every memory strobe without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all handshake/memory outputs; memory strobes are zero
    // outside ACCESS so the memory never sees a stray write.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 8'h0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = wr;
                bus.mem_addr   = base + {30'b0, k};
                bus.mem_wdata  = wdata[{k, 3'b000} +: 8];
                if (k == last_k) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, byte counter and load-data assembly. Acceptance clears
    // the previous response so rsp_rdata is 0 for stores and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 2'd0;
            last_k <= 2'd0;
            base   <= 32'h0;
            wdata  <= 32'h0;
            wr     <= 1'b0;
            rdata  <= 32'h0;
            err    <= 1'b0;
        end else if (accept) begin
            k      <= 2'd0;
            last_k <= req_last;
            base   <= bus.req_addr;
            wdata  <= bus.req_wdata;
            wr     <= bus.req_wr;
            rdata  <= 32'h0;
            err    <= req_err;
        end else if (state == S_ACCESS) begin
            if (!wr) begin
                rdata[{k, 3'b000} +: 8] <= bus.mem_rdata;
            end
            k <= k + 2'd1;
        end
    end

    assign bus.rsp_err   = err;
    assign bus.rsp_rdata = rdata;

endmodule

// File: tb/tb_word_access_sequencer.sv
// Testbench for word_access_sequencer: a byte memory attached to the memory
// port, a shadow memory as reference model, directed scenarios and a
// randomized request stream.
module tb_word_access_sequencer;

    localparam logic [31:0] MEMSIZE = 32'h400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_mem = 1'b0;

    int checks = 0;
    int failures = 0;

    word_access_sequencer_if bus ();

    word_access_sequencer #(.MEMSIZE(MEMSIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT and the reference copy.
    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    assign bus.mem_rdata = (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:0]] : 8'h00;

    // Byte memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (bus.mem_enable && bus.mem_wr && (bus.mem_addr < 32'd1024)) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
    end

    // Observations of one transaction.
    int          obs_en_cnt, obs_rsp_cyc, obs_stray, obs_ready_busy, obs_extra_rsp;
    logic        obs_err, obs_ready_after, obs_hold;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr [4];
    logic [7:0]  obs_wd   [4];
    logic        obs_wr   [4];

    // Reference model: applies a request to the shadow memory.
    task automatic model_exec(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic e, output logic [31:0] rd,
                              output int n);
        n  = (size == 2'd2) ? 4 : (size == 2'd1) ? 2 : 1;
        e  = (size == 2'd3) || ((addr % n) != 0) || ((64'(addr) + 64'(n)) > 64'(MEMSIZE));
        rd = 32'h0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (wr) ref_mem[addr + i] = wdata[8*i +: 8];
                else    rd[8*i +: 8]      = ref_mem[addr + i];
            end
        end
    endtask

    // Issue one request and record what the DUT does in the following cycles.
    task automatic run_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        obs_en_cnt = 0; obs_rsp_cyc = 0; obs_stray = 0; obs_ready_busy = 0; obs_extra_rsp = 0;
        obs_err = 1'b0; obs_rdata = 32'h0; obs_ready_after = 1'b0; obs_hold = 1'b0;
        @(negedge clk);
        bus.req_wr = wr; bus.req_size = size; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.req_valid = 1'b0;
                bus.req_wr    = 1'($urandom);
                bus.req_size  = 2'($urandom);
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
            end
            if (bus.mem_enable) begin
                if (obs_en_cnt < 4) begin
                    obs_addr[obs_en_cnt] = bus.mem_addr;
                    obs_wd[obs_en_cnt]   = bus.mem_wdata;
                    obs_wr[obs_en_cnt]   = bus.mem_wr;
                end
                obs_en_cnt++;
            end else if (bus.mem_wr || (bus.mem_addr != 0) || (bus.mem_wdata != 0)) begin
                obs_stray++;
            end
            if (obs_rsp_cyc == 0) begin
                if (bus.req_ready) obs_ready_busy++;
                if (bus.rsp_valid) begin
                    obs_rsp_cyc = cyc;
                    obs_rdata   = bus.rsp_rdata;
                    obs_err     = bus.rsp_err;
                end
            end else begin
                if (bus.rsp_valid) obs_extra_rsp++;
                obs_ready_after = bus.req_ready;
                obs_hold = (bus.rsp_rdata === obs_rdata) && (bus.rsp_err === obs_err);
                break;
            end
        end
    endtask

    task automatic test_reset();
        init_mem = 1'b1;
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'hA5;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
        checks++; if ({bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 42'h0) begin
            failures++; $display("FAIL reset_mem_outputs got en=%b wr=%b addr=%h wd=%h exp=all 0",
                                 bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        init_mem = 1'b0;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ((bus.req_ready !== 1'b1) || (bus.mem_enable !== 1'b0)) begin
            failures++; $display("FAIL post_reset_idle got ready=%b en=%b exp ready=1 en=0", bus.req_ready, bus.mem_enable);
        end
    endtask

    task automatic test_word_store_load();
        logic e; logic [31:0] rd; int n;
        run_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        model_exec(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, e, rd, n);
        checks++; if (obs_en_cnt !== 4) begin failures++; $display("FAIL wstore_enables got=%0d exp=4", obs_en_cnt); end
        checks++; if ((obs_rsp_cyc !== 5) || (obs_err !== 1'b0) || (obs_rdata !== 32'h0)) begin
            failures++; $display("FAIL wstore_rsp got cyc=%0d err=%b rd=%h exp cyc=5 err=0 rd=0", obs_rsp_cyc, obs_err, obs_rdata);
        end
        checks++; if ({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wstore_bytes got=%h %h %h %h exp=EF BE AD DE",
                                 mem[32'h100], mem[32'h101], mem[32'h102], mem[32'h103]);
        end
        run_req(1'b0, 2'd2, 32'h100, 32'h0);
        checks++; if (obs_en_cnt !== 4) begin failures++; $display("FAIL wload_enables got=%0d exp=4", obs_en_cnt); end
        checks++; if ((obs_rsp_cyc !== 5) || (obs_err !== 1'b0) || (obs_rdata !== 32'hDEADBEEF)) begin
            failures++; $display("FAIL wload_rsp got cyc=%0d err=%b rd=%h exp cyc=5 err=0 rd=deadbeef", obs_rsp_cyc, obs_err, obs_rdata);
        end
    endtask

    task automatic test_sub_word_loads();
        logic [1:0]  sz  [2] = '{2'd1, 2'd0};
        logic [31:0] ad  [2] = '{32'h102, 32'h101};
        logic [31:0] exd [2] = '{32'h0000DEAD, 32'h000000BE};
        int          exc [2] = '{3, 2};
        for (int i = 0; i < 2; i++) begin
            run_req(1'b0, sz[i], ad[i], 32'h0);
            checks++; if ((obs_rsp_cyc !== exc[i]) || (obs_err !== 1'b0) || (obs_rdata !== exd[i])) begin
                failures++; $display("FAIL subword_load[%0d] got cyc=%0d err=%b rd=%h exp cyc=%0d err=0 rd=%h",
                                     i, obs_rsp_cyc, obs_err, obs_rdata, exc[i], exd[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ad [3] = '{32'h102, 32'h001, 32'h000};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, sz[i], ad[i], $urandom);
            checks++; if ((obs_rsp_cyc !== 1) || (obs_err !== 1'b1) || (obs_rdata !== 32'h0) || (obs_en_cnt !== 0)) begin
                failures++; $display("FAIL error_req[%0d] got cyc=%0d err=%b rd=%h en=%0d exp cyc=1 err=1 rd=0 en=0",
                                     i, obs_rsp_cyc, obs_err, obs_rdata, obs_en_cnt);
            end
        end
    endtask

    task automatic test_bounds();
        logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
        logic [31:0] ad [4] = '{32'h3FC, 32'h3FF, 32'h400, 32'hFFFFFFFC};
        logic        ex [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic e; logic [31:0] rd; int n;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, sz[i], ad[i], 32'h0);
            model_exec(1'b0, sz[i], ad[i], 32'h0, e, rd, n);
            checks++; if ((obs_err !== ex[i]) || (obs_rdata !== rd) || (obs_rsp_cyc !== (ex[i] ? 1 : n + 1))
                          || (obs_en_cnt !== (ex[i] ? 0 : n))) begin
                failures++; $display("FAIL bounds[%0d] got err=%b rd=%h cyc=%0d en=%0d exp err=%b rd=%h",
                                     i, obs_err, obs_rdata, obs_rsp_cyc, obs_en_cnt, ex[i], rd);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int rsp_seen = 0;
        @(negedge clk);
        bus.req_wr = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h200; bus.req_wdata = 32'h11223344;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (bus.mem_enable !== 1'b1) begin failures++; $display("FAIL midreset_before got en=%b exp=1", bus.mem_enable); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_enable !== 1'b0) begin failures++; $display("FAIL midreset_enable_drop got en=%b exp=0", bus.mem_enable); end
        repeat (2) begin @(negedge clk); if (bus.rsp_valid) rsp_seen++; end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", bus.req_ready); end
        repeat (5) begin if (bus.rsp_valid || bus.mem_enable) rsp_seen++; @(negedge clk); end
        checks++; if (rsp_seen !== 0) begin failures++; $display("FAIL midreset_no_rsp got=%0d exp=0", rsp_seen); end
        checks++; if ({mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]}
                      !== {ref_mem[32'h203], ref_mem[32'h202], 8'h33, 8'h44}) begin
            failures++; $display("FAIL midreset_bytes got=%h %h %h %h exp=44 33 %h %h",
                                 mem[32'h200], mem[32'h201], mem[32'h202], mem[32'h203], ref_mem[32'h202], ref_mem[32'h203]);
        end
        ref_mem[32'h200] = 8'h44;
        ref_mem[32'h201] = 8'h33;
    endtask

    task automatic test_back_to_back();
        int acc [3] = '{-100, -100, -100};
        logic [7:0] bt [3];
        logic [31:0] wd;
        int idx = 0, pulses = 0, busy_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) pulses++;
            if ((bus.mem_enable || bus.rsp_valid) && bus.req_ready) busy_ready++;
            if (bus.req_ready) begin
                if (idx < 3) begin
                    wd = $urandom;
                    bt[idx] = wd[7:0];
                    acc[idx] = c;
                    bus.req_wr = 1'b1; bus.req_size = 2'd0; bus.req_addr = 32'h10 + 32'(idx); bus.req_wdata = wd;
                    bus.req_valid = 1'b1;
                    idx++;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        checks++; if ((acc[1] - acc[0] !== 3) || (acc[2] - acc[1] !== 3)) begin
            failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]);
        end
        checks++; if (pulses !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        checks++; if (busy_ready !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", busy_ready); end
        for (int i = 0; i < 3; i++) ref_mem[32'h10 + i] = bt[i];
        checks++; if ({mem[32'h12], mem[32'h11], mem[32'h10]} !== {bt[2], bt[1], bt[0]}) begin
            failures++; $display("FAIL b2b_bytes got=%h %h %h exp=%h %h %h",
                                 mem[32'h10], mem[32'h11], mem[32'h12], bt[0], bt[1], bt[2]);
        end
    endtask

    task automatic test_random();
        logic wr; logic [1:0] size; logic [31:0] addr, wdata;
        logic e; logic [31:0] rd; int n, exp_en, bus_bad, mism;
        for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: size = 2'd0;
                3, 4, 5: size = 2'd1;
                6, 7, 8: size = 2'd2;
                default: size = 2'd3;
            endcase
            case ($urandom_range(0, 5))
                0, 1:    addr = $urandom_range(0, 1023) & 32'hFFFFFFFC;
                2:       addr = $urandom_range(0, 1023);
                3:       addr = 32'h3F8 + $urandom_range(0, 8);
                4:       addr = 32'hFFFFFFF8 + $urandom_range(0, 7);
                default: addr = $urandom;
            endcase
            wdata = $urandom;
            run_req(wr, size, addr, wdata);
            model_exec(wr, size, addr, wdata, e, rd, n);
            exp_en = e ? 0 : n;
            checks++; if ((obs_rsp_cyc !== (e ? 1 : n + 1)) || (obs_err !== e) || (obs_rdata !== rd)) begin
                failures++; $display("FAIL rand[%0d] rsp got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h (wr=%b sz=%0d a=%h)",
                                     t, obs_rsp_cyc, obs_err, obs_rdata, e ? 1 : n + 1, e, rd, wr, size, addr);
            end
            bus_bad = 0;
            for (int i = 0; i < exp_en; i++) begin
                if ((obs_addr[i] !== addr + 32'(i)) || (obs_wr[i] !== wr) || (obs_wd[i] !== wdata[8*i +: 8])) bus_bad++;
            end
            checks++; if ((obs_en_cnt !== exp_en) || (bus_bad !== 0) || (obs_stray !== 0)) begin
                failures++; $display("FAIL rand[%0d] membus got en=%0d bad=%0d stray=%0d exp en=%0d bad=0 stray=0",
                                     t, obs_en_cnt, bus_bad, obs_stray, exp_en);
            end
            checks++; if ((obs_ready_busy !== 0) || (obs_extra_rsp !== 0) || (obs_ready_after !== 1'b1) || (obs_hold !== 1'b1)) begin
                failures++; $display("FAIL rand[%0d] handshake got busy_ready=%0d extra=%0d ready_after=%b hold=%b exp 0 0 1 1",
                                     t, obs_ready_busy, obs_extra_rsp, obs_ready_after, obs_hold);
            end
        end
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        checks++; if (mism !== 0) begin failures++; $display("FAIL final_memory got mismatching_bytes=%0d exp=0", mism); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_word_store_load();
        test_sub_word_loads();
        test_errors();
        test_bounds();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/word_access_sequencer.md
# word_access_sequencer

Initiator for the byte-wide data memory port: it accepts one 8/16/32-bit load or store per request from the CPU datapath and performs it as one byte access per cycle, little-endian, on the memory's `enable`/`wr`/`addr`/`data_in`/`data_out` port. It sits between the core's load/store stage and the byte memory. It also checks alignment and bounds, and returns one response per request.

## Interface
- `MEMSIZE`, default 32'h400: memory size in bytes. This is the bound for the range check.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_addr`  in  32  byte address of the lowest byte.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_err`  out  1  request was rejected (alignment, range or size); qualified by `rsp_valid`.
- `rsp_rdata`  out  32  load data, zero-extended; 0 for stores and errors.
- `mem_enable`  out  1  to memory `enable`.
- `mem_wr`  out  1  to memory `wr`.
- `mem_addr`  out  32  to memory `addr`.
- `mem_wdata`  out  8  to memory `data_in`.
- `mem_rdata`  in  8  from memory `data_out`; combinational, valid in the same cycle.

## Operation
- State machine: IDLE, ACCESS, RESP. Reset drives state to IDLE.
- `req_ready` = (state == IDLE).
- Acceptance happens on a rising edge where `req_valid && req_ready`. At acceptance the block latches addr, wdata, wr and size, and sets byte count N = 1, 2 or 4.
- Error check happens at acceptance. Any of the following is an error:
  - `req_size` = 11.
  - half with addr[0] set.
  - word with addr[1:0] != 0.
  - addr + N - 1 >= MEMSIZE. Compute this in 33 bits so there is no wrap at 32'hFFFFFFFF.
- On error: go to RESP directly with err = 1. No memory cycle is issued.
- No error: go to ACCESS with byte index k = 0.
- ACCESS, each cycle:
  - `mem_enable` = 1, `mem_wr` = latched wr, `mem_addr` = base + k.
  - `mem_wdata` = wdata[8k+7:8k].
  - On a load, `mem_rdata` is captured into rdata[8k+7:8k] at the rising edge ending the cycle.
  - k increments each cycle. After byte N-1, go to RESP.
- RESP: assert `rsp_valid` for exactly one cycle, then go to IDLE. There is no response backpressure.
- Byte order is little-endian: byte k of the data is at base + k. Unread upper bytes of `rsp_rdata` are 0.
- Outside ACCESS, `mem_enable`, `mem_wr`, `mem_addr` and `mem_wdata` are all 0. The memory therefore never sees a concurrent read and write, or a stray write.

## Timing
- Reset values while `rst_n` is low: state IDLE, k = 0, and `rsp_valid`, `rsp_err`, `rsp_rdata` and all `mem_*` outputs 0.
- `req_ready` reads 1 during reset. No request is accepted while `rst_n` is low.
- Cycle numbering: let cycle 1 be the first cycle after the acceptance edge.
  - Good requests: ACCESS occupies cycles 1..N and `rsp_valid` is high in cycle N+1.
  - Word request: 4 memory cycles, response in cycle 5.
  - Byte request: response in cycle 2.
  - Error: `rsp_valid` and `rsp_err` are high in cycle 1 with `rsp_rdata` = 0.
- `req_ready` rises in the cycle after RESP. Minimum request spacing is N+2 cycles for good requests and 2 cycles for errors.
- `rsp_rdata` and `rsp_err` are meaningful only while `rsp_valid` is high. They hold their value until the next acceptance, which clears them.
- Request inputs are ignored outside the acceptance edge. Changing them mid-operation has no effect.
- Reset asserted mid-ACCESS:
  - `mem_enable` drops immediately (asynchronously).
  - No response is issued for the aborted request.
  - Bytes already written remain in memory; the partial store is not rolled back.
- Boundary: a word at MEMSIZE-4 is legal. Any access touching byte MEMSIZE is an error.

## Test plan
- Word store 32'hDEADBEEF to 0x100, then word load from 0x100:
  - memory bytes 0x100..0x103 = EF, BE, AD, DE.
  - each request shows 4 `mem_enable` cycles.
  - load `rsp_rdata` = 32'hDEADBEEF with `rsp_valid` in cycle 5 and `rsp_err` = 0.
- Half load from 0x102 after the store above: `rsp_rdata` = 32'h0000DEAD with `rsp_valid` in cycle 3. Byte load from 0x101: `rsp_rdata` = 32'h000000BE with `rsp_valid` in cycle 2.
- Misaligned and illegal requests: each gives `rsp_err` = 1 in cycle 1 with `rsp_rdata` = 0, and `mem_enable` never rises.
  - word at 0x102.
  - half at 0x001.
  - size 11 at 0x000.
- Bounds with MEMSIZE = 32'h400:
  - word at 0x3FC succeeds.
  - half at 0x3FF is an error.
  - byte at 0x400 is an error.
  - word at 32'hFFFFFFFC is an error (no wrap).
- Reset mid-store: drop `rst_n` after 2 ACCESS cycles of a word store 32'h11223344 to 0x200.
  - `mem_enable` = 0 immediately and no `rsp_valid`.
  - memory bytes 0x200 = 44 and 0x201 = 33; bytes 0x202 and 0x203 are unchanged.
  - after release, `req_ready` = 1.
- Back-to-back requests: hold `req_valid` high with three byte stores to 0x10, 0x11, 0x12.
  - acceptances occur every 3 cycles.
  - exactly 3 `rsp_valid` pulses.
  - `req_ready` low during ACCESS and RESP.
